// File: rtl/axil_master_bridge.sv
// Simple request/response to AXI4-Lite master bridge.
// A single transaction is in flight at a time: a request is taken in IDLE,
// driven onto the read or write channels, and completed with a one-cycle
// resp_valid pulse carrying read data and the slave error flag.
//
//   state          | meaning
//   ---------------+-----------------------------------------------------
//   IDLE           | ready for a new request, req_ready high
//   RD_ADDR        | arvalid high with the registered address
//   RD_DATA        | rready high, waiting for the read beat
//   WR_ADDR_DATA   | awvalid/wvalid high until each has handshaken
//   WR_RESP        | bready high, waiting for the write response
module axil_master_bridge #(
   parameter int ADDR_WIDTH = 30,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,

   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb,

   output logic                    resp_valid,
   output logic [DATA_WIDTH-1:0]   resp_rdata,
   output logic                    resp_err,

   output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
   output logic [2:0]              m_axil_awprot,
   output logic                    m_axil_awvalid,
   input  logic                    m_axil_awready,

   output logic [DATA_WIDTH-1:0]   m_axil_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
   output logic                    m_axil_wvalid,
   input  logic                    m_axil_wready,

   input  logic [1:0]              m_axil_bresp,
   input  logic                    m_axil_bvalid,
   output logic                    m_axil_bready,

   output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
   output logic [2:0]              m_axil_arprot,
   output logic                    m_axil_arvalid,
   input  logic                    m_axil_arready,

   input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
   input  logic [1:0]              m_axil_rresp,
   input  logic                    m_axil_rvalid,
   output logic                    m_axil_rready
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   localparam logic [2:0] S_IDLE         = 3'd0;
   localparam logic [2:0] S_RD_ADDR      = 3'd1;
   localparam logic [2:0] S_RD_DATA      = 3'd2;
   localparam logic [2:0] S_WR_ADDR_DATA = 3'd3;
   localparam logic [2:0] S_WR_RESP      = 3'd4;

   logic [2:0]            state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic                  aw_done;
   logic                  w_done;

   logic req_fire;
   logic aw_hs;
   logic w_hs;
   logic aw_complete;
   logic w_complete;

   // Only bit 1 of an AXI response distinguishes OKAY/EXOKAY from errors.
   logic unused_resp_bits;
   assign unused_resp_bits = m_axil_rresp[0] ^ m_axil_bresp[0];

   // Channel controls decode straight from registered state, so they cannot
   // glitch or change while a handshake is pending.
   assign req_ready      = (state == S_IDLE);
   assign m_axil_arvalid = (state == S_RD_ADDR);
   assign m_axil_rready  = (state == S_RD_DATA);
   assign m_axil_awvalid = (state == S_WR_ADDR_DATA) && !aw_done;
   assign m_axil_wvalid  = (state == S_WR_ADDR_DATA) && !w_done;
   assign m_axil_bready  = (state == S_WR_RESP);

   assign m_axil_awaddr = addr_q;
   assign m_axil_araddr = addr_q;
   assign m_axil_awprot = 3'b000;
   assign m_axil_arprot = 3'b000;
   assign m_axil_wdata  = wdata_q;
   assign m_axil_wstrb  = wstrb_q;

   assign req_fire    = req_valid && req_ready;
   assign aw_hs       = m_axil_awvalid && m_axil_awready;
   assign w_hs        = m_axil_wvalid && m_axil_wready;
   assign aw_complete = aw_done || aw_hs;
   assign w_complete  = w_done || w_hs;

   // Transaction sequencer; the read/write direction is carried by the state
   // chosen at accept time, so no separate direction register is kept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_fire) begin
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  wstrb_q <= req_wstrb;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  state   <= req_we ? S_WR_ADDR_DATA : S_RD_ADDR;
               end
            end
            S_RD_ADDR: begin
               if (m_axil_arready) begin
                  state <= S_RD_DATA;
               end
            end
            S_RD_DATA: begin
               if (m_axil_rvalid) begin
                  resp_rdata <= m_axil_rdata;
                  resp_err   <= m_axil_rresp[1];
                  resp_valid <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            S_WR_ADDR_DATA: begin
               aw_done <= aw_complete;
               w_done  <= w_complete;
               if (aw_complete && w_complete) begin
                  state <= S_WR_RESP;
               end
            end
            S_WR_RESP: begin
               if (m_axil_bvalid) begin
                  resp_err   <= m_axil_bresp[1];
                  resp_valid <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axil_master_bridge.sv
// Bench for axil_master_bridge: a configurable-latency AXI-lite slave, a
// response scoreboard and one task per scenario.
module tb_axil_master_bridge;

   localparam int AW = 30;
   localparam int DW = 32;

   typedef struct {
      logic          is_rd;
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   logic            clk;
   logic            rst;
   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   logic [AW-1:0]   req_addr;
   logic [DW-1:0]   req_wdata;
   logic [DW/8-1:0] req_wstrb;
   logic            resp_valid;
   logic [DW-1:0]   resp_rdata;
   logic            resp_err;
   logic [AW-1:0]   awaddr;
   logic [2:0]      awprot;
   logic            awvalid;
   logic            awready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wvalid;
   logic            wready;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;
   logic [AW-1:0]   araddr;
   logic [2:0]      arprot;
   logic            arvalid;
   logic            arready;
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;
   logic            rvalid;
   logic            rready;

   int checks = 0;
   int errors = 0;
   int resp_cnt = 0;
   exp_t sb[$];

   // slave configuration
   int            aw_wait = 0;
   int            w_wait  = 0;
   int            ar_wait = 0;
   int            r_wait  = 0;
   int            b_wait  = 0;
   logic [DW-1:0] slv_rdata = '0;
   logic [1:0]    slv_rresp = 2'b00;
   logic [1:0]    slv_bresp = 2'b00;

   axil_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .req_wstrb      (req_wstrb),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_err       (resp_err),
      .m_axil_awaddr  (awaddr),
      .m_axil_awprot  (awprot),
      .m_axil_awvalid (awvalid),
      .m_axil_awready (awready),
      .m_axil_wdata   (wdata),
      .m_axil_wstrb   (wstrb),
      .m_axil_wvalid  (wvalid),
      .m_axil_wready  (wready),
      .m_axil_bresp   (bresp),
      .m_axil_bvalid  (bvalid),
      .m_axil_bready  (bready),
      .m_axil_araddr  (araddr),
      .m_axil_arprot  (arprot),
      .m_axil_arvalid (arvalid),
      .m_axil_arready (arready),
      .m_axil_rdata   (rdata),
      .m_axil_rresp   (rresp),
      .m_axil_rvalid  (rvalid),
      .m_axil_rready  (rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave: each channel answers after its configured number of wait cycles.
   initial begin
      int cnt_aw, cnt_w, cnt_ar, cnt_r, cnt_b;
      cnt_aw = 0; cnt_w = 0; cnt_ar = 0; cnt_r = 0; cnt_b = 0;
      awready = 0; wready = 0; arready = 0; rvalid = 0; bvalid = 0;
      rdata = '0; rresp = 2'b00; bresp = 2'b00;
      forever begin
         @(posedge clk); #1;
         if (awvalid) begin
            if (cnt_aw >= aw_wait) awready = 1; else begin awready = 0; cnt_aw++; end
         end else begin awready = 0; cnt_aw = 0; end
         if (wvalid) begin
            if (cnt_w >= w_wait) wready = 1; else begin wready = 0; cnt_w++; end
         end else begin wready = 0; cnt_w = 0; end
         if (arvalid) begin
            if (cnt_ar >= ar_wait) arready = 1; else begin arready = 0; cnt_ar++; end
         end else begin arready = 0; cnt_ar = 0; end
         if (rready) begin
            if (cnt_r >= r_wait) begin rvalid = 1; rdata = slv_rdata; rresp = slv_rresp; end
            else begin rvalid = 0; cnt_r++; end
         end else begin rvalid = 0; cnt_r = 0; end
         if (bready) begin
            if (cnt_b >= b_wait) begin bvalid = 1; bresp = slv_bresp; end
            else begin bvalid = 0; cnt_b++; end
         end else begin bvalid = 0; cnt_b = 0; end
      end
   end

   // Monitor: pops the scoreboard on every completion pulse.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (arvalid && awvalid) begin
            checks++; errors++;
            $display("FAIL ar_aw_overlap arvalid=%b awvalid=%b required not both", arvalid, awvalid);
         end
         if (resp_valid) begin
            resp_cnt++;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_resp resp_valid=1 with no outstanding request");
            end else begin
               e = sb.pop_front();
               if (resp_err !== e.err) begin
                  errors++;
                  $display("FAIL resp_err got=%b exp=%b", resp_err, e.err);
               end
               if (e.is_rd) begin
                  checks++;
                  if (resp_rdata !== e.rdata) begin
                     errors++;
                     $display("FAIL resp_rdata got=%h exp=%h", resp_rdata, e.rdata);
                  end
               end
            end
         end
      end
   end

   // Present a request and hold it until the accept edge; returns at #1 after it.
   task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [DW/8-1:0] ws, input logic [DW-1:0] exp_rd, input logic exp_err);
      int n = 0;
      exp_t e;
      req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws; req_valid = 1;
      while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
      checks++;
      if (!req_ready) begin
         errors++;
         $display("FAIL accept_timeout req_ready=%b exp=1", req_ready);
         req_valid = 0;
      end else begin
         @(posedge clk);
         e.is_rd = !we; e.rdata = exp_rd; e.err = exp_err;
         sb.push_back(e);
         #1;
         req_valid = 0;
      end
   endtask

   task automatic wait_resp(input int start);
      int n = 0;
      while (resp_cnt <= start && n < 100) begin @(posedge clk); #1; n++; end
      checks++;
      if (resp_cnt <= start) begin
         errors++;
         $display("FAIL resp_timeout resp_cnt=%0d exp>%0d", resp_cnt, start);
      end
   endtask

   task automatic test_reset();
      rst = 1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_err} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl got=%b exp=0000000",
                  {arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_err});
      end
      checks++;
      if (resp_rdata !== '0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_data rdata=%h req_ready=%b exp rdata=0 req_ready=1", resp_rdata, req_ready);
      end
      checks++;
      if (awprot !== 3'b000 || arprot !== 3'b000) begin
         errors++;
         $display("FAIL prot awprot=%b arprot=%b exp=000", awprot, arprot);
      end
      rst = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_write_zero_wait();
      aw_wait = 0; w_wait = 0; b_wait = 0; slv_bresp = 2'b00;
      issue(1'b1, 30'hC, 32'h0000_0007, 4'hF, '0, 1'b0);
      checks++;
      if (awvalid !== 1 || wvalid !== 1 || awaddr !== 30'hC || wdata !== 32'h7 || wstrb !== 4'hF) begin
         errors++;
         $display("FAIL wr_n1 awv=%b wv=%b addr=%h data=%h strb=%h exp 1 1 c 7 f",
                  awvalid, wvalid, awaddr, wdata, wstrb);
      end
      @(posedge clk); #1;
      checks++;
      if (bready !== 1 || awvalid !== 0 || wvalid !== 0) begin
         errors++;
         $display("FAIL wr_n2 bready=%b awv=%b wv=%b exp 1 0 0", bready, awvalid, wvalid);
      end
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1 || resp_err !== 0) begin
         errors++;
         $display("FAIL wr_n3 resp_valid=%b resp_err=%b exp 1 0", resp_valid, resp_err);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_read_wait();
      int start;
      start = resp_cnt;
      ar_wait = 0; r_wait = 4; slv_rdata = 32'h0000_0007; slv_rresp = 2'b00;
      issue(1'b0, 30'hC, '0, '0, 32'h0000_0007, 1'b0);
      checks++;
      if (arvalid !== 1 || araddr !== 30'hC) begin
         errors++;
         $display("FAIL rd_ar arvalid=%b araddr=%h exp 1 c", arvalid, araddr);
      end
      wait_resp(start);
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (resp_cnt !== start + 1) begin
         errors++;
         $display("FAIL rd_single_pulse pulses=%0d exp=1", resp_cnt - start);
      end
      checks++;
      if (resp_rdata !== 32'h7) begin
         errors++;
         $display("FAIL rd_hold resp_rdata=%h exp=00000007", resp_rdata);
      end
      r_wait = 0;
   endtask

   task automatic test_write_aw_delay();
      int aw_cyc = 0;
      int w_cyc = 0;
      int start;
      start = resp_cnt;
      aw_wait = 3; w_wait = 0;
      issue(1'b1, 30'h10, 32'hA5A5_5A5A, 4'h3, '0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         if (!awvalid && !wvalid) break;
         if (awvalid) begin
            aw_cyc++;
            checks++;
            if (awaddr !== 30'h10) begin
               errors++;
               $display("FAIL aw_stable awaddr=%h exp=10", awaddr);
            end
         end
         if (wvalid) w_cyc++;
         @(posedge clk); #1;
      end
      checks++;
      if (w_cyc !== 1 || aw_cyc !== 4) begin
         errors++;
         $display("FAIL aw_delay w_cycles=%0d aw_cycles=%0d exp 1 4", w_cyc, aw_cyc);
      end
      checks++;
      if (bready !== 1) begin
         errors++;
         $display("FAIL aw_delay_bready bready=%b exp=1", bready);
      end
      wait_resp(start);
      aw_wait = 0;
   endtask

   task automatic test_read_err();
      int start;
      start = resp_cnt;
      slv_rdata = 32'hDEAD_BEEF; slv_rresp = 2'b10;
      issue(1'b0, 30'h20, '0, '0, 32'hDEAD_BEEF, 1'b1);
      wait_resp(start);
      start = resp_cnt;
      slv_rdata = 32'h1234_5678; slv_rresp = 2'b00;
      issue(1'b0, 30'h24, '0, '0, 32'h1234_5678, 1'b0);
      wait_resp(start);
      start = resp_cnt;
      slv_bresp = 2'b11;
      issue(1'b1, 30'h28, 32'h1, 4'h1, '0, 1'b1);
      wait_resp(start);
      slv_bresp = 2'b00;
   endtask

   task automatic test_back_to_back();
      int start;
      int n = 0;
      exp_t e;
      start = resp_cnt;
      slv_rdata = 32'h0000_0011; slv_rresp = 2'b00;
      issue(1'b0, 30'h30, '0, '0, 32'h0000_0011, 1'b0);
      while (!resp_valid && n < 50) begin @(posedge clk); #1; n++; end
      slv_rdata = 32'h0000_0022;
      req_we = 0; req_addr = 30'h34; req_valid = 1;
      checks++;
      if (resp_valid !== 1 || req_ready !== 1) begin
         errors++;
         $display("FAIL b2b_ready resp_valid=%b req_ready=%b exp 1 1", resp_valid, req_ready);
      end
      @(posedge clk);
      e.is_rd = 1; e.rdata = 32'h0000_0022; e.err = 0;
      sb.push_back(e);
      #1;
      req_valid = 0;
      checks++;
      if (arvalid !== 1 || araddr !== 30'h34) begin
         errors++;
         $display("FAIL b2b_ar arvalid=%b araddr=%h exp 1 34", arvalid, araddr);
      end
      wait_resp(start + 1);
   endtask

   task automatic test_reset_mid_read();
      int start;
      int n = 0;
      r_wait = 10; slv_rdata = 32'h0000_0099;
      issue(1'b0, 30'h40, '0, '0, 32'h0000_0099, 1'b0);
      while (!rready && n < 20) begin @(posedge clk); #1; n++; end
      start = resp_cnt;
      rst = 1;
      #1;
      checks++;
      if ({arvalid, awvalid, wvalid, rready, bready, resp_valid} !== 6'b0) begin
         errors++;
         $display("FAIL rst_mid got=%b exp=000000",
                  {arvalid, awvalid, wvalid, rready, bready, resp_valid});
      end
      sb.delete();
      @(posedge clk); #1;
      rst = 0;
      r_wait = 0;
      @(posedge clk); #1;
      checks++;
      if (req_ready !== 1) begin
         errors++;
         $display("FAIL rst_mid_ready req_ready=%b exp=1", req_ready);
      end
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (resp_cnt !== start) begin
         errors++;
         $display("FAIL rst_mid_noresp pulses=%0d exp=0", resp_cnt - start);
      end
   endtask

   initial begin
      test_reset();
      test_write_zero_wait();
      test_read_wait();
      test_write_aw_delay();
      test_read_err();
      test_back_to_back();
      test_reset_mid_read();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain outstanding=%0d exp=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
